mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port round-robin arbiter that shares the single-port 256×16 program/data memory between two requesters: port 0, instruction fetch, and port 1, data load/store. It accepts at most one access per cycle and drives the memory's enable, write, address and data lines. It routes each read response back to the port that issued it, tagged and registered. It sits between the processor's fetch/execute logic and the memory array, replacing direct array indexing.

## Interface
- ADDR_W, 8, memory address width (256 words)
- DATA_W, 16, memory word width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- r0_req / r1_req  in  1  access request; held until granted
- r0_addr / r1_addr  in  ADDR_W  word address
- r0_we / r1_we  in  1  1 = write, 0 = read
- r0_wdata / r1_wdata  in  DATA_W  write data
- r0_lock / r1_lock  in  1  keep priority after this grant (read-modify-write)
- r0_gnt / r1_gnt  out  1  combinational grant; an access transfers on an edge where req & gnt
- r0_rvalid / r1_rvalid  out  1  registered one-cycle read-data strobe
- r0_rdata / r1_rdata  out  DATA_W  registered read data; holds last value when rvalid low
- mem_en  out  1  memory access enable (combinational)
- mem_we  out  1  memory write enable (combinational)
- mem_addr  out  ADDR_W  memory address (combinational)
- mem_wdata  out  DATA_W  memory write data (combinational)
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en & !mem_we

## Operation
- State: prio (1 bit, port currently favoured), pend_v, pend_tag (read in flight), rdata/rvalid registers per port.
- Grant, when rst is 0:
  - r0_gnt = r0_req & (!r1_req | prio==0)
  - r1_gnt = r1_req & (!r0_req | prio==1)
  - At most one gnt is ever high.
- rst high forces both gnt, mem_en and mem_we to 0 combinationally.
- Memory mux: mem_en = r0_gnt | r1_gnt. mem_we, mem_addr and mem_wdata come from the granted port, and are 0 when no port is granted.
- Priority update on each accept by port i:
  - r_i_lock = 0: prio ← other port.
  - r_i_lock = 1: prio ← i.
  - No accept: prio unchanged.
  - An uncontended accept also updates prio.
- Read pipeline:
  - On a read accept by port i: pend_v ← 1, pend_tag ← i. Otherwise pend_v ← 0.
  - When pend_v: r_{pend_tag}_rdata ← mem_rdata and r_{pend_tag}_rvalid ← 1. All other rvalid ← 0.
- Writes produce no rvalid.
- Back-to-back accepts, including alternating ports, are fully pipelined; there are no bubbles.
- Requester must keep addr/we/wdata/lock stable while req is high and gnt is low. Dropping req before a grant is legal and cancels the request.

## Timing
- Reset values: prio=0, pend_v=0, r0/r1_rvalid=0, r0/r1_rdata=0. gnt and mem_* read 0 while rst is high.
- Accept at edge E: memory samples at E; mem_rdata is valid in the cycle after E; rvalid is high in the cycle after E+1.
- Read latency: 2 cycles from the accepting edge to the rvalid cycle.
- Throughput: 1 access per cycle.
- Contended worst-case wait: 1 cycle when neither port holds lock. A port holding lock continuously starves the other; this is intended, and firmware bounds lock to 1 access.
- Reset mid-operation: an in-flight read is discarded. rvalid stays 0 in the cycle after the reset edge; prio returns to 0.
- Simultaneous read and write to the same address on consecutive cycles: ordering is acceptance order; the memory defines read-during-write behaviour.

## Test plan
- Reset then idle: rst=1 for 2 cycles with both req=1 → both gnt=0, mem_en=0. After release, first contended cycle grants port 0; all rvalid=0, rdata=0.
- Single read: mem[0x05]=0x0107, r1 reads 0x05 → r1_gnt=1 in the same cycle, mem_addr=0x05. r1_rvalid=1 with r1_rdata=0x0107 exactly 2 cycles after the accept edge; r0_rvalid stays 0.
- Contention alternation: both ports request reads continuously (r0 addr 0x00, r1 addr 0x10) → grants alternate 0,1,0,1. rvalid strobes alternate with correct data per port, one accept per cycle.
- Write then read: r1 writes 0xBEEF to 0x20, then r0 reads 0x20 → r0_rdata=0xBEEF, and no rvalid follows the write.
- Lock: r1 holds lock=1 and req=1 with r0 requesting → r1 granted on consecutive cycles. Dropping lock gives r0 the next grant.
- Reset mid-read: assert rst on the cycle after a read accept → no rvalid afterward, and prio=0 after reset.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus between the two memory requesters, the arbiter and the single-port memory.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              r0_req;
   logic [ADDR_W-1:0] r0_addr;
   logic              r0_we;
   logic [DATA_W-1:0] r0_wdata;
   logic              r0_lock;
   logic              r0_gnt;
   logic              r0_rvalid;
   logic [DATA_W-1:0] r0_rdata;

   logic              r1_req;
   logic [ADDR_W-1:0] r1_addr;
   logic              r1_we;
   logic [DATA_W-1:0] r1_wdata;
   logic              r1_lock;
   logic              r1_gnt;
   logic              r1_rvalid;
   logic [DATA_W-1:0] r1_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  r0_req, r0_addr, r0_we, r0_wdata, r0_lock,
      input  r1_req, r1_addr, r1_we, r1_wdata, r1_lock,
      input  mem_rdata,
      output r0_gnt, r0_rvalid, r0_rdata,
      output r1_gnt, r1_rvalid, r1_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output r0_req, r0_addr, r0_we, r0_wdata, r0_lock,
      output r1_req, r1_addr, r1_we, r1_wdata, r1_lock,
      output mem_rdata,
      input  r0_gnt, r0_rvalid, r0_rdata,
      input  r1_gnt, r1_rvalid, r1_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// (port 0) and data load/store (port 1); read data is routed back by tag.
module mem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);
   typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_t;

   port_t             prio;
   port_t             pend_tag;
   logic              pend_v;
   logic              gnt0, gnt1;
   logic              we_mux;
   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] wdata_mux;
   logic              rvalid0, rvalid1;
   logic [DATA_W-1:0] rdata0, rdata1;

   // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      we_mux    = 1'b0;
      addr_mux  = '0;
      wdata_mux = '0;
      if (!rst) begin
         gnt0 = bus.r0_req & (!bus.r1_req | (prio == PORT0));
         gnt1 = bus.r1_req & (!bus.r0_req | (prio == PORT1));
      end
      if (gnt0) begin
         we_mux    = bus.r0_we;
         addr_mux  = bus.r0_addr;
         wdata_mux = bus.r0_wdata;
      end else if (gnt1) begin
         we_mux    = bus.r1_we;
         addr_mux  = bus.r1_addr;
         wdata_mux = bus.r1_wdata;
      end
   end

   assign bus.r0_gnt    = gnt0;
   assign bus.r1_gnt    = gnt1;
   assign bus.mem_en    = gnt0 | gnt1;
   assign bus.mem_we    = we_mux;
   assign bus.mem_addr  = addr_mux;
   assign bus.mem_wdata = wdata_mux;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values, whatever the statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         prio     <= PORT0;
         pend_v   <= 1'b0;
         pend_tag <= PORT0;
         rvalid0  <= 1'b0;
         rvalid1  <= 1'b0;
         rdata0   <= '0;
         rdata1   <= '0;
      end else begin
         // A locked accept keeps priority with the same port for its follow-up access.
         if (gnt0)
            prio <= bus.r0_lock ? PORT0 : PORT1;
         else if (gnt1)
            prio <= bus.r1_lock ? PORT1 : PORT0;

         pend_v   <= (gnt0 | gnt1) & !we_mux;
         pend_tag <= gnt1 ? PORT1 : PORT0;

         rvalid0 <= pend_v & (pend_tag == PORT0);
         rvalid1 <= pend_v & (pend_tag == PORT1);
         if (pend_v && pend_tag == PORT0)
            rdata0 <= bus.mem_rdata;
         if (pend_v && pend_tag == PORT1)
            rdata1 <= bus.mem_rdata;
      end
   end

   assign bus.r0_rvalid = rvalid0;
   assign bus.r1_rvalid = rvalid1;
   assign bus.r0_rdata  = rdata0;
   assign bus.r1_rdata  = rdata1;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous 256x16 memory model behind it.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

   mem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Memory model: write or read sampled on the edge, read data valid the following cycle.
   logic [15:0] mem [256];
   logic [15:0] mem_q = '0;
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         else            mem_q <= mem[bus.mem_addr];
      end
   end
   assign bus.mem_rdata = mem_q;

   task automatic idle_inputs();
      bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_lock = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
      bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_lock = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.r0_req = 1'b1; bus.r1_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         n_cmp++; if (bus.r0_gnt !== 1'b0) begin n_err++; $display("FAIL reset_r0_gnt: got %b want 0", bus.r0_gnt); end
         n_cmp++; if (bus.r1_gnt !== 1'b0) begin n_err++; $display("FAIL reset_r1_gnt: got %b want 0", bus.r1_gnt); end
         n_cmp++; if (bus.mem_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_en: got %b want 0", bus.mem_en); end
      end
      n_cmp++; if (bus.r0_rvalid !== 1'b0 || bus.r1_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b%b want 00", bus.r0_rvalid, bus.r1_rvalid); end
      n_cmp++; if (bus.r0_rdata !== 16'h0 || bus.r1_rdata !== 16'h0) begin n_err++; $display("FAIL reset_rdata: got %h/%h want 0000/0000", bus.r0_rdata, bus.r1_rdata); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (bus.r0_gnt !== 1'b1) begin n_err++; $display("FAIL first_contend_r0_gnt: got %b want 1", bus.r0_gnt); end
      n_cmp++; if (bus.r1_gnt !== 1'b0) begin n_err++; $display("FAIL first_contend_r1_gnt: got %b want 0", bus.r1_gnt); end
      // Cancel both requests before the edge so nothing is accepted.
      bus.r0_req = 1'b0; bus.r1_req = 1'b0;
      #1;
      n_cmp++; if (bus.mem_en !== 1'b0) begin n_err++; $display("FAIL cancel_mem_en: got %b want 0", bus.mem_en); end
      step();
   endtask

   task automatic preload(input logic [7:0] addr, input logic [15:0] data);
      bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = addr; bus.r0_wdata = data;
      step();
      idle_inputs();
   endtask

   task automatic test_single_read();
      bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 8'h05;
      #1;
      n_cmp++; if (bus.r1_gnt !== 1'b1 || bus.r0_gnt !== 1'b0) begin n_err++; $display("FAIL single_gnt: got r0=%b r1=%b want r0=0 r1=1", bus.r0_gnt, bus.r1_gnt); end
      n_cmp++; if (bus.mem_addr !== 8'h05 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0) begin n_err++; $display("FAIL single_mem: got en=%b we=%b addr=%h want en=1 we=0 addr=05", bus.mem_en, bus.mem_we, bus.mem_addr); end
      step();
      bus.r1_req = 1'b0;
      n_cmp++; if (bus.r1_rvalid !== 1'b0) begin n_err++; $display("FAIL single_early_rvalid: got %b want 0", bus.r1_rvalid); end
      step();
      n_cmp++; if (bus.r1_rvalid !== 1'b1 || bus.r1_rdata !== 16'h0107) begin n_err++; $display("FAIL single_r1_rdata: got v=%b d=%h want v=1 d=0107", bus.r1_rvalid, bus.r1_rdata); end
      n_cmp++; if (bus.r0_rvalid !== 1'b0) begin n_err++; $display("FAIL single_r0_rvalid: got %b want 0", bus.r0_rvalid); end
      step();
      n_cmp++; if (bus.r1_rvalid !== 1'b0 || bus.r1_rdata !== 16'h0107) begin n_err++; $display("FAIL single_strobe_len: got v=%b d=%h want v=0 d=0107", bus.r1_rvalid, bus.r1_rdata); end
   endtask

   task automatic test_back_to_back();
      bus.r0_we = 1'b0; bus.r0_addr = 8'h00;
      bus.r1_we = 1'b0; bus.r1_addr = 8'h10;
      for (int k = 0; k < 6; k++) begin
         bus.r0_req = (k < 4);
         bus.r1_req = (k < 4);
         #1;
         if (k < 4) begin
            n_cmp++; if (bus.r0_gnt !== ((k % 2) == 0) || bus.r1_gnt !== ((k % 2) == 1)) begin n_err++; $display("FAIL alt_gnt[%0d]: got r0=%b r1=%b want port %0d", k, bus.r0_gnt, bus.r1_gnt, k % 2); end
            n_cmp++; if (bus.mem_addr !== (((k % 2) == 1) ? 8'h10 : 8'h00)) begin n_err++; $display("FAIL alt_addr[%0d]: got %h", k, bus.mem_addr); end
         end
         if (k >= 2) begin
            n_cmp++; if (bus.r0_rvalid !== ((k % 2) == 0) || bus.r1_rvalid !== ((k % 2) == 1)) begin n_err++; $display("FAIL alt_rvalid[%0d]: got r0=%b r1=%b want port %0d", k, bus.r0_rvalid, bus.r1_rvalid, k % 2); end
            if ((k % 2) == 0) begin
               n_cmp++; if (bus.r0_rdata !== 16'h1111) begin n_err++; $display("FAIL alt_r0_rdata[%0d]: got %h want 1111", k, bus.r0_rdata); end
            end else begin
               n_cmp++; if (bus.r1_rdata !== 16'h2222) begin n_err++; $display("FAIL alt_r1_rdata[%0d]: got %h want 2222", k, bus.r1_rdata); end
            end
         end else begin
            n_cmp++; if (bus.r0_rvalid !== 1'b0 || bus.r1_rvalid !== 1'b0) begin n_err++; $display("FAIL alt_rvalid_early[%0d]: got %b%b want 00", k, bus.r0_rvalid, bus.r1_rvalid); end
         end
         step();
      end
      idle_inputs();
   endtask

   task automatic test_write_read();
      bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_addr = 8'h20; bus.r1_wdata = 16'hBEEF;
      #1;
      n_cmp++; if (bus.r1_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 16'hBEEF) begin n_err++; $display("FAIL wr_mem: got gnt=%b we=%b wdata=%h want 1/1/beef", bus.r1_gnt, bus.mem_we, bus.mem_wdata); end
      step();
      bus.r1_req = 1'b0; bus.r1_we = 1'b0;
      bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 8'h20;
      #1;
      n_cmp++; if (bus.r0_gnt !== 1'b1 || bus.mem_we !== 1'b0) begin n_err++; $display("FAIL rd_after_wr_gnt: got gnt=%b we=%b want 1/0", bus.r0_gnt, bus.mem_we); end
      step();
      bus.r0_req = 1'b0;
      n_cmp++; if (bus.r0_rvalid !== 1'b0 || bus.r1_rvalid !== 1'b0) begin n_err++; $display("FAIL wr_no_rvalid: got %b%b want 00", bus.r0_rvalid, bus.r1_rvalid); end
      step();
      n_cmp++; if (bus.r0_rvalid !== 1'b1 || bus.r0_rdata !== 16'hBEEF) begin n_err++; $display("FAIL rd_after_wr_data: got v=%b d=%h want v=1 d=beef", bus.r0_rvalid, bus.r0_rdata); end
      n_cmp++; if (bus.r1_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_after_wr_r1v: got %b want 0", bus.r1_rvalid); end
      step();
   endtask

   task automatic test_lock();
      // Priority sits with port 1 here; the lock must hold it for a second grant.
      bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 8'h00;
      bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_addr = 8'h30; bus.r1_wdata = 16'h1234; bus.r1_lock = 1'b1;
      #1;
      n_cmp++; if (bus.r1_gnt !== 1'b1 || bus.r0_gnt !== 1'b0) begin n_err++; $display("FAIL lock_gnt0: got r0=%b r1=%b want r1", bus.r0_gnt, bus.r1_gnt); end
      step();
      n_cmp++; if (bus.r1_gnt !== 1'b1 || bus.r0_gnt !== 1'b0) begin n_err++; $display("FAIL lock_gnt1: got r0=%b r1=%b want r1", bus.r0_gnt, bus.r1_gnt); end
      step();
      bus.r1_lock = 1'b0;
      #1;
      n_cmp++; if (bus.r1_gnt !== 1'b1 || bus.r0_gnt !== 1'b0) begin n_err++; $display("FAIL lock_gnt2: got r0=%b r1=%b want r1", bus.r0_gnt, bus.r1_gnt); end
      step();
      n_cmp++; if (bus.r0_gnt !== 1'b1 || bus.r1_gnt !== 1'b0) begin n_err++; $display("FAIL unlock_gnt: got r0=%b r1=%b want r0", bus.r0_gnt, bus.r1_gnt); end
      step();
      idle_inputs();
      step();
      step();
   endtask

   task automatic test_reset_mid_read();
      bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 8'h05;
      #1;
      n_cmp++; if (bus.r1_gnt !== 1'b1) begin n_err++; $display("FAIL midrst_gnt: got %b want 1", bus.r1_gnt); end
      step();
      rst = 1'b1;
      bus.r0_req = 1'b1;
      #1;
      n_cmp++; if (bus.r0_gnt !== 1'b0 || bus.r1_gnt !== 1'b0 || bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin n_err++; $display("FAIL midrst_forced: got gnt=%b%b en=%b we=%b want 0", bus.r0_gnt, bus.r1_gnt, bus.mem_en, bus.mem_we); end
      step();
      rst = 1'b0;
      #1;
      n_cmp++; if (bus.r0_rvalid !== 1'b0 || bus.r1_rvalid !== 1'b0) begin n_err++; $display("FAIL midrst_rvalid: got %b%b want 00", bus.r0_rvalid, bus.r1_rvalid); end
      n_cmp++; if (bus.r0_gnt !== 1'b1 || bus.r1_gnt !== 1'b0) begin n_err++; $display("FAIL midrst_prio: got r0=%b r1=%b want r0", bus.r0_gnt, bus.r1_gnt); end
      idle_inputs();
      step();
      n_cmp++; if (bus.r1_rvalid !== 1'b0) begin n_err++; $display("FAIL midrst_rvalid_late: got %b want 0", bus.r1_rvalid); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time %0t reached limit", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      preload(8'h05, 16'h0107);
      preload(8'h00, 16'h1111);
      preload(8'h10, 16'h2222);
      test_single_read();
      test_back_to_back();
      test_write_read();
      test_lock();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
